// File: rtl/l1_bus_pkg.sv
// -----------------------------------------------------------------------------
// l1_bus_pkg
// Shared constants for L1 interconnect device adapters.
//   L1_DATA_WIDTH      : default data bus width
//   L1_ADDR_DEV_WIDTH  : default device-local address width
//   L1_DEV_ADDR_WIDTH  : width of the peripheral-side address bus
// Response entries are packed as {ini_addr, rdata}: the initiator tag sits in
// the MSBs and the read data in the LSBs. l1_resp_t shows that layout for the
// default (single tag bit, 32-bit data) configuration.
// -----------------------------------------------------------------------------
package l1_bus_pkg;

    localparam int L1_DATA_WIDTH     = 32;
    localparam int L1_ADDR_DEV_WIDTH = 20;
    localparam int L1_DEV_ADDR_WIDTH = 32;

    typedef struct packed {
        logic [0:0]               ini_addr;
        logic [L1_DATA_WIDTH-1:0] rdata;
    } l1_resp_t;

    // Total width of one {ini_addr, rdata} response entry.
    function automatic int resp_entry_width(input int ini_w, input int data_w);
        return ini_w + data_w;
    endfunction

endpackage

// File: rtl/l1_resp_fifo.sv
// -----------------------------------------------------------------------------
// l1_resp_fifo
// Small circular response buffer with occupancy count.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   push_i        : write wdata_i at the tail (caller guarantees not full,
//                   unless a pop happens in the same cycle)
//   pop_i         : drop the head entry (caller guarantees not empty)
//   rdata_o       : head entry, forced to zero while empty
//   full_o        : count == Depth
//   empty_o       : count == 0
//   count_o       : number of stored entries
// -----------------------------------------------------------------------------
module l1_resp_fifo #(
    parameter int Depth = 3,
    parameter int Width = 33
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       push_i,
    input  logic [Width-1:0]           wdata_i,
    input  logic                       pop_i,
    output logic [Width-1:0]           rdata_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(Depth+1)-1:0] count_o
);

    localparam int CntW = $clog2(Depth + 1);
    localparam int PtrW = (Depth > 1) ? $clog2(Depth) : 1;

    logic [Width-1:0] mem_q [Depth];
    logic [Width-1:0] mem_d [Depth];
    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]  count_q, count_d;

    // Pointers wrap modulo Depth, which need not be a power of two.
    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
    endfunction

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_i) begin
            mem_d[wr_ptr_q] = wdata_i;
            wr_ptr_d        = ptr_inc(wr_ptr_q);
        end
        if (pop_i) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        case ({push_i, pop_i})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: nothing is visible until count_q says so.
    always_ff @(posedge clk_i) begin
        mem_q <= mem_d;
    end

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CntW'(Depth));
    assign count_o = count_q;
    assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q];

endmodule

// File: rtl/l1_device_adapter.sv
// -----------------------------------------------------------------------------
// l1_device_adapter
// Bridges an L1 interconnect target port to a simple single-cycle peripheral.
// Requests are forwarded combinationally; the peripheral answers exactly one
// cycle later and its answer is tagged and buffered in a response FIFO.
//   req_*   : interconnect request (valid/ready)
//   resp_*  : interconnect response (valid/ready), FIFO head
//   dev_*   : peripheral strobe interface
//   err_o   : sticky protocol error (spurious or missing dev_rvalid_i)
// Handshake: a transfer happens in a cycle where valid and ready are both 1;
// valid must not depend on ready, and req_ready_o depends on registered state
// only, never on resp_ready_i.
// -----------------------------------------------------------------------------
module l1_device_adapter
    import l1_bus_pkg::*;
#(
    parameter int DataWidth    = L1_DATA_WIDTH,
    parameter int AddrWidth    = L1_ADDR_DEV_WIDTH,
    parameter int NbrHostsLog2 = 1,
    parameter int RespDepth    = 3
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    req_valid_i,
    output logic                    req_ready_o,
    input  logic [NbrHostsLog2-1:0] req_ini_addr_i,
    input  logic [AddrWidth-1:0]    req_tgt_addr_i,
    input  logic                    req_wen_i,
    input  logic [DataWidth-1:0]    req_wdata_i,
    input  logic [DataWidth/8-1:0]  req_be_i,
    output logic                    resp_valid_o,
    input  logic                    resp_ready_i,
    output logic [NbrHostsLog2-1:0] resp_ini_addr_o,
    output logic [DataWidth-1:0]    resp_rdata_o,
    output logic                    dev_req_o,
    output logic                    dev_we_o,
    output logic [DataWidth/8-1:0]  dev_be_o,
    output logic [31:0]             dev_addr_o,
    output logic [DataWidth-1:0]    dev_wdata_o,
    input  logic                    dev_rvalid_i,
    input  logic [DataWidth-1:0]    dev_rdata_i,
    output logic                    err_o
);

    localparam int CntW   = $clog2(RespDepth + 1);
    localparam int EntryW = resp_entry_width(NbrHostsLog2, DataWidth);

    logic                    inflight_q, inflight_d;
    logic [NbrHostsLog2-1:0] tag_q, tag_d;
    logic                    err_q, err_d;

    logic                    accept;
    logic [CntW:0]           occupancy;
    logic                    fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [CntW-1:0]         fifo_count;
    logic [DataWidth-1:0]    push_rdata;
    logic [EntryW-1:0]       fifo_wdata, fifo_rdata;

    // Buffered responses plus the one in flight must always fit, so a request
    // is only taken when its response is guaranteed a slot.
    assign occupancy   = {1'b0, fifo_count} + {{CntW{1'b0}}, inflight_q};
    assign req_ready_o = (occupancy < (CntW + 1)'(RespDepth));
    assign accept      = req_valid_i & req_ready_o;

    assign dev_req_o   = accept;
    assign dev_we_o    = req_wen_i;
    assign dev_be_o    = req_be_i;
    assign dev_addr_o  = 32'(req_tgt_addr_i);
    assign dev_wdata_o = req_wdata_i;

    always_comb begin
        inflight_d = accept;
        tag_d      = accept ? req_ini_addr_i : tag_q;
        // Spurious answer while idle, or no answer when one was due.
        err_d      = err_q | (dev_rvalid_i & ~inflight_q) | (inflight_q & ~dev_rvalid_i);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            inflight_q <= 1'b0;
            tag_q      <= '0;
            err_q      <= 1'b0;
        end else begin
            inflight_q <= inflight_d;
            tag_q      <= tag_d;
            err_q      <= err_d;
        end
    end

    // An in-flight request always produces an entry; if the peripheral stays
    // silent the entry carries zero data so the initiator is not left hanging.
    assign push_rdata = dev_rvalid_i ? dev_rdata_i : '0;
    assign fifo_wdata = {tag_q, push_rdata};
    assign fifo_pop   = ~fifo_empty & resp_ready_i;
    assign fifo_push  = inflight_q & (~fifo_full | fifo_pop);

    l1_resp_fifo #(
        .Depth (RespDepth),
        .Width (EntryW)
    ) u_resp_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (fifo_push),
        .wdata_i (fifo_wdata),
        .pop_i   (fifo_pop),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    assign resp_valid_o                    = ~fifo_empty;
    assign {resp_ini_addr_o, resp_rdata_o} = fifo_rdata;
    assign err_o                           = err_q;

endmodule

// File: tb/tb_l1_device_adapter.sv
// -----------------------------------------------------------------------------
// tb_l1_device_adapter
// Directed and random stimulus for l1_device_adapter. The reference model keeps
// the buffered responses and in-flight tags as queues; readiness is their
// combined size against the response depth.
// -----------------------------------------------------------------------------
module tb_l1_device_adapter;

  localparam int DEPTH = 3;

  logic        clk;
  logic        rst_ni;
  logic        req_valid_i;
  logic        req_ready_o;
  logic [0:0]  req_ini_addr_i;
  logic [19:0] req_tgt_addr_i;
  logic        req_wen_i;
  logic [31:0] req_wdata_i;
  logic [3:0]  req_be_i;
  logic        resp_valid_o;
  logic        resp_ready_i;
  logic [0:0]  resp_ini_addr_o;
  logic [31:0] resp_rdata_o;
  logic        dev_req_o;
  logic        dev_we_o;
  logic [3:0]  dev_be_o;
  logic [31:0] dev_addr_o;
  logic [31:0] dev_wdata_o;
  logic        dev_rvalid_i;
  logic [31:0] dev_rdata_i;
  logic        err_o;

  l1_device_adapter dut (
    .clk_i           (clk),
    .rst_ni          (rst_ni),
    .req_valid_i     (req_valid_i),
    .req_ready_o     (req_ready_o),
    .req_ini_addr_i  (req_ini_addr_i),
    .req_tgt_addr_i  (req_tgt_addr_i),
    .req_wen_i       (req_wen_i),
    .req_wdata_i     (req_wdata_i),
    .req_be_i        (req_be_i),
    .resp_valid_o    (resp_valid_o),
    .resp_ready_i    (resp_ready_i),
    .resp_ini_addr_o (resp_ini_addr_o),
    .resp_rdata_o    (resp_rdata_o),
    .dev_req_o       (dev_req_o),
    .dev_we_o        (dev_we_o),
    .dev_be_o        (dev_be_o),
    .dev_addr_o      (dev_addr_o),
    .dev_wdata_o     (dev_wdata_o),
    .dev_rvalid_i    (dev_rvalid_i),
    .dev_rdata_i     (dev_rdata_i),
    .err_o           (err_o)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- model / scoreboard state ----------------
  logic [32:0] exp_q[$];    // buffered responses {tag, rdata}
  logic [0:0]  infl_q[$];   // tags of requests awaiting the peripheral
  bit          exp_err;

  int n_cmp;
  int n_mis;
  int dut_acc;

  // peripheral behaviour controls
  bit          pend_rv;
  logic [31:0] pend_rd;
  bit          drop_resp;
  bit          spur_now;
  bit          use_rd;
  logic [31:0] fixed_rd;

  task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  // One clock cycle. Inputs were set at the preceding negedge; outputs are
  // checked 1 ns later, then the model advances on the rising edge.
  task automatic cycle();
    bit          exp_ready;
    bit          exp_acc;
    bit          do_pop;
    bit          do_push;
    logic [0:0]  t;
    dev_rvalid_i = pend_rv | spur_now;
    dev_rdata_i  = pend_rv ? pend_rd : $urandom();
    #1;
    exp_ready = (exp_q.size() + infl_q.size()) < DEPTH;
    exp_acc   = req_valid_i && exp_ready;
    check("req_ready", req_ready_o, exp_ready);
    check("dev_req", dev_req_o, exp_acc);
    if (exp_acc) begin
      check("dev_we", dev_we_o, req_wen_i);
      check("dev_be", dev_be_o, req_be_i);
      check("dev_addr", dev_addr_o, {12'h000, req_tgt_addr_i});
      check("dev_wdata", dev_wdata_o, req_wdata_i);
    end
    check("resp_valid", resp_valid_o, exp_q.size() > 0);
    if (exp_q.size() > 0) begin
      check("resp_ini_addr", resp_ini_addr_o, exp_q[0][32]);
      check("resp_rdata", resp_rdata_o, exp_q[0][31:0]);
    end
    check("err", err_o, exp_err);
    if (dev_req_o === 1'b1) dut_acc++;
    @(posedge clk);
    do_pop  = (exp_q.size() > 0) && resp_ready_i;
    do_push = infl_q.size() > 0;
    if (do_push && !do_pop) begin
      assert (exp_q.size() < DEPTH) else begin
        n_mis++;
        $error("FAIL no_overflow: observed %0d expected < %0d", exp_q.size(), DEPTH);
      end
    end
    if (do_pop) void'(exp_q.pop_front());
    if (do_push) begin
      t = infl_q.pop_front();
      if (dev_rvalid_i) exp_q.push_back({t, dev_rdata_i});
      else begin
        exp_q.push_back({t, 32'h0});
        exp_err = 1'b1;
      end
    end else if (dev_rvalid_i) begin
      exp_err = 1'b1;
    end
    if (exp_acc) infl_q.push_back(req_ini_addr_i);
    pend_rv = exp_acc && !drop_resp;
    pend_rd = use_rd ? fixed_rd : $urandom();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_ni       = 1'b0;
    req_valid_i  = 1'b0;
    dev_rvalid_i = 1'b0;
    spur_now     = 1'b0;
    pend_rv      = 1'b0;
    exp_q.delete();
    infl_q.delete();
    exp_err = 1'b0;
    #1;
    check("rst_req_ready", req_ready_o, 1'b1);
    check("rst_resp_valid", resp_valid_o, 1'b0);
    check("rst_dev_req", dev_req_o, 1'b0);
    check("rst_err", err_o, 1'b0);
    check("rst_resp_rdata", resp_rdata_o, 32'h0);
    check("rst_resp_ini", resp_ini_addr_o, 1'b0);
    @(posedge clk);
    @(negedge clk);
    rst_ni = 1'b1;
  endtask

  task automatic set_req(input bit v, input logic [0:0] tag, input logic [19:0] a,
                         input bit w, input logic [31:0] wd, input logic [3:0] be);
    req_valid_i    = v;
    req_ini_addr_i = tag;
    req_tgt_addr_i = a;
    req_wen_i      = w;
    req_wdata_i    = wd;
    req_be_i       = be;
  endtask

  initial begin
    n_cmp = 0; n_mis = 0; dut_acc = 0;
    pend_rv = 0; pend_rd = '0; drop_resp = 0; spur_now = 0; use_rd = 0; fixed_rd = '0;
    exp_err = 0;
    resp_ready_i = 1'b1;
    dev_rdata_i  = '0;
    set_req(0, 0, 0, 0, 0, 0);
    do_reset();

    // single read: tag 1, addr 0x004, peripheral returns 0xDEADBEEF
    use_rd = 1; fixed_rd = 32'hDEADBEEF;
    set_req(1, 1, 20'h00004, 0, 0, 4'hF);
    cycle();
    set_req(0, 0, 0, 0, 0, 0);
    cycle();
    cycle();
    cycle();
    use_rd = 0;

    // back-to-back reads, alternating tags
    dut_acc = 0;
    for (int i = 0; i < 6; i++) begin
      set_req(1, 1'(i % 2), 20'(i * 4), 0, 0, 4'hF);
      cycle();
    end
    set_req(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) cycle();
    check("b2b_accepts", dut_acc, 6);

    // backpressure: responses stall, only three requests fit
    resp_ready_i = 1'b0;
    dut_acc = 0;
    for (int i = 0; i < 6; i++) begin
      set_req(1, 1'(i % 2), 20'h00100 + 20'(i), 0, 0, 4'hF);
      cycle();
    end
    check("bp_accepts", dut_acc, 3);
    set_req(0, 0, 0, 0, 0, 0);
    resp_ready_i = 1'b1;
    for (int i = 0; i < 4; i++) cycle();

    // write with partial byte enables
    set_req(1, 0, 20'h00040, 1, 32'h0000ABCD, 4'b0011);
    cycle();
    set_req(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) cycle();

    // random traffic
    for (int i = 0; i < 400; i++) begin
      set_req($urandom_range(0, 9) < 7, 1'($urandom_range(0, 1)), 20'($urandom()),
              1'($urandom_range(0, 1)), $urandom(), 4'($urandom_range(0, 15)));
      resp_ready_i = $urandom_range(0, 9) < 6;
      cycle();
    end
    set_req(0, 0, 0, 0, 0, 0);
    resp_ready_i = 1'b1;
    for (int i = 0; i < 4; i++) cycle();

    // reset with two responses buffered and one in flight
    resp_ready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      set_req(1, 1'(i % 2), 20'(i), 0, 0, 4'hF);
      cycle();
    end
    do_reset();
    resp_ready_i = 1'b1;
    use_rd = 1; fixed_rd = 32'h12345678;
    set_req(1, 1, 20'h00008, 0, 0, 4'hF);
    cycle();
    set_req(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) cycle();
    use_rd = 0;

    // spurious peripheral response while idle
    cycle();
    spur_now = 1'b1;
    cycle();
    spur_now = 1'b0;
    for (int i = 0; i < 3; i++) cycle();
    do_reset();

    // missing peripheral response
    drop_resp = 1'b1;
    set_req(1, 1, 20'h00010, 0, 0, 4'hF);
    cycle();
    drop_resp = 1'b0;
    set_req(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) cycle();
    do_reset();
    cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/l1_device_adapter.md
L1_DEVICE_ADAPTER -- requirements
Module: l1_device_adapter

Interface
REQ-001 SHALL have parameters, one per line: name, default, meaning.
- DataWidth, 32, data/rdata width.
- AddrWidth, 20, interconnect device address width.
- NbrHostsLog2, 1, initiator tag width.
- RespDepth, 3, response FIFO entries (minimum 2).

REQ-002 SHALL have ports, one per line: name, direction, width, meaning. One clock; reset is asynchronous and active-low.
- clk_i, in, 1, clock.
- rst_ni, in, 1, async active-low reset.
- req_valid_i, in, 1, interconnect request valid.
- req_ready_o, out, 1, adapter accepts request.
- req_ini_addr_i, in, NbrHostsLog2, initiator tag.
- req_tgt_addr_i, in, AddrWidth, device-local byte address.
- req_wen_i, in, 1, write enable.
- req_wdata_i, in, DataWidth, write data.
- req_be_i, in, DataWidth/8, byte enables.
- resp_valid_o, out, 1, response valid.
- resp_ready_i, in, 1, interconnect takes response.
- resp_ini_addr_o, out, NbrHostsLog2, tag of the response.
- resp_rdata_o, out, DataWidth, response data.
- dev_req_o, out, 1, peripheral request strobe.
- dev_we_o, out, 1, peripheral write enable.
- dev_be_o, out, DataWidth/8, peripheral byte enables.
- dev_addr_o, out, 32, zero-extended req_tgt_addr_i.
- dev_wdata_o, out, DataWidth, peripheral write data.
- dev_rvalid_i, in, 1, peripheral response, exactly 1 cycle after dev_req_o.
- dev_rdata_i, in, DataWidth, peripheral read data.
- err_o, out, 1, sticky protocol error.

Function
REQ-003 Accept = req_valid_i and req_ready_o; dev_req_o SHALL equal accept combinationally.
REQ-004 dev_we_o, dev_be_o, dev_addr_o, dev_wdata_o SHALL pass through the req_* fields combinationally.
REQ-005 On accept, the adapter SHALL register req_ini_addr_i into the tag register and set inflight=1; with no accept, inflight SHALL be cleared to 0.
REQ-006 Every accepted request, read or write, SHALL yield exactly one response. For a write, the response rdata SHALL be dev_rdata_i as returned.
REQ-007 When dev_rvalid_i=1 and inflight=1, {tag, dev_rdata_i} SHALL be pushed into the response FIFO.
REQ-008 req_ready_o SHALL be 1 iff count + inflight < RespDepth, using registered values only (no combinational path from resp_ready_i).
REQ-009 resp_valid_o SHALL be 1 iff count > 0; resp_ini_addr_o and resp_rdata_o SHALL show the FIFO head.
REQ-010 Pop SHALL occur when resp_valid_o=1 and resp_ready_i=1. The response SHALL stay stable while resp_valid_o=1 and resp_ready_i=0.
REQ-011 Simultaneous push and pop SHALL leave count unchanged and preserve order. Pointers SHALL wrap modulo RespDepth.
REQ-012 Minimum latency SHALL be: accept at cycle N, resp_valid_o at cycle N+2.
REQ-013 With RespDepth=3, continuous req_valid_i, and resp_ready_i=1, one request SHALL be accepted per cycle.
REQ-014 err_o SHALL be set and held until reset on either protocol violation:
- dev_rvalid_i=1 while inflight=0 (the response is dropped);
- inflight=1 while dev_rvalid_i=0 (a response {tag, 0} is pushed so the initiator never hangs).
REQ-015 A push when count=RespDepth SHALL be unreachable by REQ-008; the bench asserts this.

Reset
REQ-016 Asynchronous reset SHALL clear count, pointers, inflight, tag and err_o. Outputs during reset: req_ready_o=1, resp_valid_o=0, dev_req_o=0, err_o=0, resp_rdata_o=0, resp_ini_addr_o=0.
REQ-017 A reset mid-transaction SHALL discard inflight and buffered responses with no response emitted. The first accept after reset release SHALL behave as from idle.

Structure
REQ-018 Package l1_bus_pkg SHALL hold L1_DATA_WIDTH=32, L1_ADDR_DEV_WIDTH=20 and the response-entry field ordering {ini_addr, rdata}.
REQ-019 The response FIFO SHALL be a sub-module l1_resp_fifo (push/pop/full/empty/count, parameter Depth, Width).

Verification
REQ-020 Single read: tag 1, addr 0x004, dev_rdata_i=0xDEADBEEF at N+1 -> resp_valid_o at N+2 with ini_addr 1 and rdata 0xDEADBEEF; popped when resp_ready_i=1.
REQ-021 Back-to-back: 6 reads, tags alternating 0/1, resp_ready_i=1 -> 6 accepts in 6 cycles; responses in order with matching tags.
REQ-022 Backpressure: resp_ready_i=0, continuous requests -> exactly 3 accepts, then req_ready_o=0 and the head stays stable. resp_ready_i=1 -> drains 3 and ready recovers.
REQ-023 Write: wen=1, be=0b0011, wdata=0x0000ABCD -> dev_we_o=1, dev_be_o=0b0011 same cycle, and exactly one response with the initiator's tag.
REQ-024 Protocol errors: spurious dev_rvalid_i while idle -> err_o=1 and no response. Missing dev_rvalid_i -> err_o=1 and response rdata 0.
REQ-025 Reset mid-op: 2 responses buffered and 1 inflight, rst_ni low -> next cycle resp_valid_o=0 and req_ready_o=1; the next read returns correctly.
